// File: rtl/dcache_flush_wb.sv
// Data-cache flush write-back engine: for each dirty way of a notified set, read
// tag and line, write the full line to memory, clear the dirty bit, then pulse fl_ready.
module dcache_flush_wb #(
    parameter  int TAG_WIDTH    = 20,
    parameter  int INDEX_WIDTH  = 6,
    parameter  int OFFSET_WIDTH = 6,
    localparam int LINE_W       = 8 << OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   fl_valid,
    input  logic [INDEX_WIDTH-1:0] fl_index,
    input  logic                   fl_way0,
    input  logic                   fl_way1,
    output logic                   fl_ready,
    output logic                   rd_en,
    output logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_way,
    input  logic [TAG_WIDTH-1:0]   tag_rdata,
    input  logic [LINE_W-1:0]      line_rdata,
    output logic [1:0]             dt_we,
    output logic [INDEX_WIDTH-1:0] dt_waddr,
    output logic                   dt_wdata,
    output logic                   wr_req,
    output logic [31:0]            wr_addr,
    output logic [LINE_W-1:0]      wr_data,
    input  logic                   wr_rdy,
    output logic                   busy
);

    if (TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH != 32) begin : g_bad_widths
        $error("dcache_flush_wb: TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH must equal 32");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_SEND,
        S_CLEAR,
        S_ACK
    } state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic                   way0_q, way0_d;
    logic                   way1_q, way1_d;
    logic [31:0]            wr_addr_q, wr_addr_d;
    logic [LINE_W-1:0]      wr_data_q, wr_data_d;

    // Way0 is always served first, so "way0 still pending" identifies the active way.
    logic cur_way;
    assign cur_way = ~way0_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            way0_q    <= 1'b0;
            way1_q    <= 1'b0;
            wr_addr_q <= '0;
            // NOTE: the line buffer is a plain register (not a RAM), so it can and
            // must be reset; the bus payload is defined as zero out of reset.
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            way0_q    <= way0_d;
            way1_q    <= way1_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        way0_d    = way0_q;
        way1_d    = way1_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (fl_valid) begin
                    if (fl_way0 || fl_way1) begin
                        idx_d   = fl_index;
                        way0_d  = fl_way0;
                        way1_d  = fl_way1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                wr_addr_d = {tag_rdata, idx_q, {OFFSET_WIDTH{1'b0}}};
                wr_data_d = line_rdata;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (wr_rdy) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (way0_q) begin
                    way0_d  = 1'b0;
                    state_d = way1_q ? S_READ : S_ACK;
                end else begin
                    way1_d  = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fl_ready = 1'b0;
        rd_en    = 1'b0;
        dt_we    = 2'b00;
        wr_req   = 1'b0;
        unique case (state_q)
            S_READ:  rd_en    = 1'b1;
            S_SEND:  wr_req   = 1'b1;
            S_CLEAR: dt_we    = cur_way ? 2'b10 : 2'b01;
            S_ACK:   fl_ready = 1'b1;
            default: ;
        endcase
    end

    assign rd_index = idx_q;
    assign rd_way   = cur_way;
    assign dt_waddr = idx_q;
    assign dt_wdata = 1'b0;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dcache_flush_wb.sv
// Bench for dcache_flush_wb: an array/memory responder, a per-notify plan model
// checked every cycle, and directed cases pinned by hand-computed values.
module tb_dcache_flush_wb;

    localparam int TW   = 20;
    localparam int IW   = 6;
    localparam int OW   = 6;
    localparam int LW   = 8 << OW;
    localparam int SETS = 1 << IW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fl_valid;
    logic [IW-1:0] fl_index;
    logic          fl_way0, fl_way1;
    logic          fl_ready;
    logic          rd_en;
    logic [IW-1:0] rd_index;
    logic          rd_way;
    logic [TW-1:0] tag_rdata;
    logic [LW-1:0] line_rdata;
    logic [1:0]    dt_we;
    logic [IW-1:0] dt_waddr;
    logic          dt_wdata;
    logic          wr_req;
    logic [31:0]   wr_addr;
    logic [LW-1:0] wr_data;
    logic          wr_rdy;
    logic          busy;

    dcache_flush_wb #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)) dut (
        .clk(clk), .rstn(rstn),
        .fl_valid(fl_valid), .fl_index(fl_index), .fl_way0(fl_way0), .fl_way1(fl_way1),
        .fl_ready(fl_ready),
        .rd_en(rd_en), .rd_index(rd_index), .rd_way(rd_way),
        .tag_rdata(tag_rdata), .line_rdata(line_rdata),
        .dt_we(dt_we), .dt_waddr(dt_waddr), .dt_wdata(dt_wdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Tag/data array: registered read, junk on every cycle that was not read.
    logic [TW-1:0] tag_mem  [SETS][2];
    logic [LW-1:0] data_mem [SETS][2];

    always @(posedge clk) begin
        if (rd_en) begin
            tag_rdata  <= tag_mem[rd_index][rd_way];
            line_rdata <= data_mem[rd_index][rd_way];
        end else begin
            tag_rdata  <= TW'($urandom);
            line_rdata <= rand_line();
        end
    end

    // Behavioural model: each accepted notify becomes a list of bus-visible steps.
    typedef enum {P_READ, P_CAPT, P_SEND, P_CLEAR, P_ACK} phase_e;
    typedef struct {
        phase_e        ph;
        logic          way;
        logic [IW-1:0] idx;
        logic [31:0]   addr;
        logic [LW-1:0] data;
    } step_t;

    step_t    plan[$];
    step_t    m_head;
    step_t    m_s;
    bit       m_was_empty;
    logic     m_rd, m_wr, m_rdy;
    logic [1:0] m_we;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_was_empty = (plan.size() == 0);
            m_rd = 1'b0; m_wr = 1'b0; m_rdy = 1'b0; m_we = 2'b00;
            if (!m_was_empty) begin
                m_head = plan[0];
                case (m_head.ph)
                    P_READ: begin
                        m_rd = 1'b1;
                        check("m_rd_index", 64'(rd_index), 64'(m_head.idx));
                        check("m_rd_way", 64'(rd_way), 64'(m_head.way));
                    end
                    P_SEND: begin
                        m_wr = 1'b1;
                        check("m_wr_addr", 64'(wr_addr), 64'(m_head.addr));
                        check_line("m_wr_data", wr_data, m_head.data);
                    end
                    P_CLEAR: begin
                        m_we = m_head.way ? 2'b10 : 2'b01;
                        check("m_dt_waddr", 64'(dt_waddr), 64'(m_head.idx));
                    end
                    P_ACK:   m_rdy = 1'b1;
                    default: ;
                endcase
            end
            check("m_rd_en", 64'(rd_en), 64'(m_rd));
            check("m_wr_req", 64'(wr_req), 64'(m_wr));
            check("m_dt_we", 64'(dt_we), 64'(m_we));
            check("m_dt_wdata", 64'(dt_wdata), 64'(0));
            check("m_fl_ready", 64'(fl_ready), 64'(m_rdy));
            check("m_busy", 64'(busy), 64'(!m_was_empty));

            if (!m_was_empty && !(m_head.ph == P_SEND && !wr_rdy)) void'(plan.pop_front());
            if (!rstn) begin
                plan.delete();
            end else if (m_was_empty && fl_valid) begin
                for (int w = 0; w < 2; w++) begin
                    if ((w == 0) ? fl_way0 : fl_way1) begin
                        m_s.way  = 1'(w);
                        m_s.idx  = fl_index;
                        m_s.addr = {tag_mem[fl_index][w], fl_index, {OW{1'b0}}};
                        m_s.data = data_mem[fl_index][w];
                        m_s.ph = P_READ;  plan.push_back(m_s);
                        m_s.ph = P_CAPT;  plan.push_back(m_s);
                        m_s.ph = P_SEND;  plan.push_back(m_s);
                        m_s.ph = P_CLEAR; plan.push_back(m_s);
                    end
                end
                m_s.ph = P_ACK;
                plan.push_back(m_s);
            end
        end
    end

    // Observations of one notify, used for the hand-computed expectations.
    int            ready_cyc, send_seen, n_rd;
    logic [31:0]   addr_q[$];
    logic [1:0]    dtwe_q[$];
    logic [IW-1:0] dtaddr_q[$];

    // mode: 0 = wr_rdy always high, 1 = low for 7 SEND cycles, 2 = random
    task automatic run_notify(input logic [IW-1:0] idx, input logic w0, input logic w1,
                              input int mode, input bit scramble);
        int cyc;
        bit done;
        addr_q.delete(); dtwe_q.delete(); dtaddr_q.delete();
        ready_cyc = -1; send_seen = 0; n_rd = 0;
        @(posedge clk); #2;
        fl_valid = 1'b1; fl_index = idx; fl_way0 = w0; fl_way1 = w1;
        wr_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
        cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); cyc++; #2;
            if (scramble) begin
                fl_index = IW'($urandom);
                fl_way0  = 1'($urandom_range(1, 0));
                fl_way1  = 1'($urandom_range(1, 0));
            end
            case (mode)
                0:       wr_rdy = 1'b1;
                1:       wr_rdy = (send_seen >= 7);
                default: wr_rdy = 1'($urandom_range(2, 0) != 0);
            endcase
            @(negedge clk);
            if (rd_en) n_rd++;
            if (wr_req) begin
                send_seen++;
                if (wr_rdy) addr_q.push_back(wr_addr);
            end
            if (dt_we != 2'b00) begin
                dtwe_q.push_back(dt_we);
                dtaddr_q.push_back(dt_waddr);
            end
            if (fl_ready) begin
                ready_cyc = cyc;
                done = 1;
            end
        end
        if (!done) check("notify_timeout", 64'(0), 64'(1));
        @(posedge clk); #2;
        fl_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                tag_mem[s][w]  = TW'($urandom);
                data_mem[s][w] = rand_line();
            end
        end
        rstn = 1'b0; fl_valid = 1'b0; fl_index = '0; fl_way0 = 1'b0; fl_way1 = 1'b0; wr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_fl_ready", 64'(fl_ready), 64'(0));
        check("rst_wr_req", 64'(wr_req), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check_line("rst_wr_data", wr_data, '0);
        check("rst_rd_index", 64'(rd_index), 64'(0));
        check("rst_dt_waddr", 64'(dt_waddr), 64'(0));
        @(posedge clk); #2;
        rstn = 1'b1;

        // 1: way0 only
        tag_mem[5][0] = 20'hABCDE;
        run_notify(6'd5, 1'b1, 1'b0, 0, 0);
        check("t1_nwrites", 64'(addr_q.size()), 64'(1));
        if (addr_q.size() >= 1) check("t1_addr", 64'(addr_q[0]), 64'(32'hABCDE140));
        check("t1_nclears", 64'(dtwe_q.size()), 64'(1));
        if (dtwe_q.size() >= 1) begin
            check("t1_dt_we", 64'(dtwe_q[0]), 64'(2'b01));
            check("t1_dt_waddr", 64'(dtaddr_q[0]), 64'(5));
        end
        check("t1_ready_cycle", 64'(ready_cyc), 64'(5));

        // 2: both ways
        tag_mem[63][0] = 20'h11111;
        tag_mem[63][1] = 20'h22222;
        run_notify(6'd63, 1'b1, 1'b1, 0, 0);
        check("t2_nwrites", 64'(addr_q.size()), 64'(2));
        if (addr_q.size() >= 2) begin
            check("t2_addr0", 64'(addr_q[0]), 64'(32'h11111FC0));
            check("t2_addr1", 64'(addr_q[1]), 64'(32'h22222FC0));
        end
        check("t2_nclears", 64'(dtwe_q.size()), 64'(2));
        if (dtwe_q.size() >= 2) begin
            check("t2_dt_we0", 64'(dtwe_q[0]), 64'(2'b01));
            check("t2_dt_we1", 64'(dtwe_q[1]), 64'(2'b10));
        end
        check("t2_ready_cycle", 64'(ready_cyc), 64'(9));

        // 3: backpressure, 7 stalled SEND cycles then acceptance
        tag_mem[10][1] = 20'h3C3C3;
        run_notify(6'd10, 1'b0, 1'b1, 1, 0);
        check("t3_send_cycles", 64'(send_seen), 64'(8));
        check("t3_nwrites", 64'(addr_q.size()), 64'(1));
        if (addr_q.size() >= 1) check("t3_addr", 64'(addr_q[0]), 64'(32'h3C3C3280));
        if (dtwe_q.size() >= 1) check("t3_dt_we", 64'(dtwe_q[0]), 64'(2'b10));
        check("t3_ready_cycle", 64'(ready_cyc), 64'(12));

        // 4: empty notify
        run_notify(6'd20, 1'b0, 1'b0, 0, 0);
        check("t4_ready_cycle", 64'(ready_cyc), 64'(1));
        check("t4_reads", 64'(n_rd), 64'(0));
        check("t4_sends", 64'(send_seen), 64'(0));
        check("t4_clears", 64'(dtwe_q.size()), 64'(0));

        // 5: reset while a write is pending
        wr_rdy = 1'b0;
        @(posedge clk); #2;
        fl_valid = 1'b1; fl_index = 6'd63; fl_way0 = 1'b1; fl_way1 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wr_req) seen = 1;
        end
        check("t5_reached_send", 64'(seen), 64'(1));
        @(posedge clk); #2;
        rstn = 1'b0; fl_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_wr_req", 64'(wr_req), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_wr_addr", 64'(wr_addr), 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("t5_no_dt_we", 64'(dt_we), 64'(0));
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        run_notify(6'd63, 1'b1, 1'b1, 0, 0);
        check("t5_after_nwrites", 64'(addr_q.size()), 64'(2));
        if (addr_q.size() >= 2) check("t5_after_addr1", 64'(addr_q[1]), 64'(32'h22222FC0));

        // 6: inputs scrambled after latching
        tag_mem[7][0] = 20'h0F0F0;
        tag_mem[7][1] = 20'h55555;
        run_notify(6'd7, 1'b1, 1'b1, 2, 1);
        check("t6_nwrites", 64'(addr_q.size()), 64'(2));
        if (addr_q.size() >= 2) begin
            check("t6_addr0", 64'(addr_q[0]), 64'(32'h0F0F01C0));
            check("t6_addr1", 64'(addr_q[1]), 64'(32'h555551C0));
        end
        if (dtaddr_q.size() >= 2) begin
            check("t6_dt_waddr0", 64'(dtaddr_q[0]), 64'(7));
            check("t6_dt_waddr1", 64'(dtaddr_q[1]), 64'(7));
        end

        // Randomized notifies against the model
        for (int n = 0; n < 40; n++) begin
            run_notify(IW'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       2, 1'($urandom_range(1, 0)));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
